apb4_user_guard: RTL and testbench
==================================

# apb4_user_guard

APB4 transfer guard placed directly upstream of the user-IP wrapper. It forwards the user-IP slot's APB4 traffic unchanged, freezes the user-IP select for the full length of each transfer, and enforces a wait-state timeout. A transfer that stalls too long is aborted and completed upstream with PSLVERR, so a hung or unimplemented user IP cannot lock the SoC bus. Aborts are counted for software diagnostics.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: maximum number of wait cycles allowed in the access phase; 0 disables the timeout.
- `CNT_WIDTH`, default `$clog2(TIMEOUT_CYCLES+1)`: width of the wait-cycle counter; derived, do not override.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `sel_i`  in  `USER_IPSEL_WIDTH`  raw user-IP select from the SoC config register.
- `sel_o`  out  `USER_IPSEL_WIDTH`  transfer-stable select, fed to the wrapper's `sel_i`.
- `apb`  `apb4_if.slave`  —  upstream port, from the peripheral decoder.
- `user`  `apb4_if.master`  —  downstream port, to the wrapper's `apb`.
- `timeout_o`  out  1  one-cycle pulse on each abort.
- `abort_cnt_o`  out  8  saturating abort count.

## Operation
- FSM states: IDLE, ACCESS, ABORT. Reset state is IDLE.
- IDLE -> ACCESS when `apb.psel=1` and `apb.penable=0` (setup phase). On that edge:
  - `sel_q` <= `sel_i`;
  - `wcnt` <= 0.
- ACCESS -> IDLE when `apb.penable=1` and `user.pready=1` (normal completion).
- ACCESS -> ABORT when `TIMEOUT_CYCLES!=0`, `apb.penable=1`, `user.pready=0` and `wcnt==TIMEOUT_CYCLES-1`.
  - Otherwise, each ACCESS cycle with `penable=1` and `pready=0` does `wcnt++`.
- ABORT -> IDLE unconditionally after one cycle.
- `sel_o`:
  - equals `sel_i` in IDLE;
  - equals `sel_q` in ACCESS and ABORT.
  - A `sel_i` change mid-transfer is therefore invisible until the next IDLE.
- Downstream request:
  - `paddr`, `pprot`, `pwrite`, `pwdata` and `pstrb` are combinational pass-through from `apb` in all states.
  - `psel` and `penable` pass through in IDLE and ACCESS, and are forced to 0 in ABORT.
- Upstream response:
  - In IDLE and ACCESS: `pready`, `prdata` and `pslverr` come from `user`.
  - In ABORT: `pready=1`, `pslverr=1`, `prdata=0`.
- `timeout_o` is 1 exactly in ABORT cycles.
- `abort_cnt_o` increments on entry to ABORT and saturates at 255.
- Simultaneous events:
  - `pready` arriving in the threshold cycle is a normal completion; no abort.
  - A late `user.pready` seen during ABORT or later in IDLE is ignored; it is not forwarded as a completion.
- Back-to-back transfers: a new setup phase in the cycle after completion or after ABORT is accepted normally.

## Timing
- Reset values:
  - FSM = IDLE, `sel_q=0`, `wcnt=0`, `timeout_o=0`, `abort_cnt_o=0`.
  - `sel_o=sel_i` (IDLE behaviour).
- Zero added latency on the normal path: request and response are combinational through the block.
- Abort timing: an access phase starting at cycle A with no `pready` runs wait cycles A .. A+TIMEOUT_CYCLES-1. ABORT then occupies cycle A+TIMEOUT_CYCLES, where upstream sees `pready=1` and `pslverr=1`.
- All registers update on the rising edge of `clk_i`. Reset assertion mid-transfer returns to IDLE immediately (asynchronous); downstream `psel` and `penable` then follow `apb` combinationally.

## Test plan
- Zero-wait read, `sel_i=2`, user returns `prdata=0xA5A5_0001`, `pready=1` in the first access cycle:
  - upstream sees that data, `pslverr=0`;
  - `abort_cnt_o=0`.
- Write with 3 wait states, `TIMEOUT_CYCLES=4`, `pready` on the 4th access cycle:
  - completes with no abort;
  - `timeout_o` stays 0.
- `TIMEOUT_CYCLES=4`, user never asserts `pready`:
  - ABORT occurs in the 5th access cycle;
  - upstream `pready=1`, `pslverr=1`, `prdata=0`; `timeout_o` pulses once;
  - `user.psel=0` in that cycle; `abort_cnt_o=1`.
- Change `sel_i` from 1 to 3 in the middle of a stalled access:
  - `sel_o` holds 1 until the cycle after completion, then becomes 3.
- 260 consecutive timed-out transfers: `abort_cnt_o` saturates at 255.
- Assert `rst_n_i` mid-ACCESS, then release: all outputs at reset values, and the next transfer completes normally.

Source files
------------

// File: rtl/apb4_user_guard_if.sv
// -----------------------------------------------------------------------------
// apb4_if
// APB4 bus bundle shared by the peripheral decoder, the user-IP guard and the
// user-IP wrapper.
//   master modport : drives the request (paddr, pprot, psel, penable, pwrite,
//                    pwdata, pstrb) and receives the response.
//   slave modport  : receives the request and drives the response (pready,
//                    prdata, pslverr).
// -----------------------------------------------------------------------------
interface apb4_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_user_guard.sv
// -----------------------------------------------------------------------------
// apb4_user_guard
// APB4 transfer guard in front of the user-IP wrapper. Traffic is forwarded
// combinationally; the user-IP select is frozen for the length of a transfer,
// and an access phase that waits too long is aborted and completed upstream
// with PSLVERR so a hung user IP cannot lock the bus.
//
// Ports:
//   clk_i        in   system clock
//   rst_n_i      in   asynchronous active-low reset
//   sel_i        in   raw user-IP select from the SoC config register
//   sel_o        out  transfer-stable select for the wrapper
//   apb          slave  upstream APB4 port (from the peripheral decoder)
//   user         master downstream APB4 port (to the wrapper)
//   timeout_o    out  high for the single cycle of each abort
//   abort_cnt_o  out  saturating count of aborts
// -----------------------------------------------------------------------------
module apb4_user_guard #(
  parameter int unsigned TIMEOUT_CYCLES   = 256,
  parameter int unsigned USER_IPSEL_WIDTH = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned CNT_WIDTH        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [USER_IPSEL_WIDTH-1:0] sel_i,
  output logic [USER_IPSEL_WIDTH-1:0] sel_o,
  apb4_if.slave                       apb,
  apb4_if.master                      user,
  output logic                        timeout_o,
  output logic [7:0]                  abort_cnt_o
);

  // With the timeout disabled CNT_WIDTH collapses to 0; keep a 1-bit counter
  // so the declarations stay legal. Its value is then never looked at.
  localparam int unsigned CW         = (CNT_WIDTH == 0) ? 1 : CNT_WIDTH;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] WCNT_LAST =
    TIMEOUT_EN ? CW'(TIMEOUT_CYCLES - 1) : {CW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ABORT  = 2'd2
  } state_e;

  state_e                      state_r;
  logic [USER_IPSEL_WIDTH-1:0] sel_q_r;
  logic [CW-1:0]               wcnt_r;
  logic                        timeout_r;
  logic [7:0]                  abort_cnt_r;

  // Transfer FSM with wait-cycle counter, latched select and abort bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      sel_q_r     <= {USER_IPSEL_WIDTH{1'b0}};
      wcnt_r      <= {CW{1'b0}};
      timeout_r   <= 1'b0;
      abort_cnt_r <= 8'd0;
    end else begin
      // timeout_r is only raised on the transition into ABORT, giving a
      // registered pulse that coincides exactly with the ABORT cycle.
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (apb.psel && !apb.penable) begin
            state_r <= ST_ACCESS;
            sel_q_r <= sel_i;
            wcnt_r  <= {CW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (apb.penable) begin
            // pready wins over the threshold: a completion in the last
            // allowed cycle is a normal completion.
            if (user.pready) begin
              state_r <= ST_IDLE;
            end else if (TIMEOUT_EN && (wcnt_r == WCNT_LAST)) begin
              state_r   <= ST_ABORT;
              timeout_r <= 1'b1;
              if (abort_cnt_r != 8'hFF) begin
                abort_cnt_r <= abort_cnt_r + 8'd1;
              end else begin
                abort_cnt_r <= abort_cnt_r;
              end
            end else begin
              wcnt_r <= wcnt_r + CW'(1);
            end
          end else begin
            state_r <= ST_ACCESS;
          end
        end
        ST_ABORT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Request fields that never need gating go straight through.
  assign user.paddr  = apb.paddr;
  assign user.pprot  = apb.pprot;
  assign user.pwrite = apb.pwrite;
  assign user.pwdata = apb.pwdata;
  assign user.pstrb  = apb.pstrb;

  assign timeout_o   = timeout_r;
  assign abort_cnt_o = abort_cnt_r;

  // State-dependent select, request gating and response muxing.
  always_comb begin
    sel_o        = sel_i;
    user.psel    = apb.psel;
    user.penable = apb.penable;
    apb.pready   = user.pready;
    apb.prdata   = user.prdata;
    apb.pslverr  = user.pslverr;
    case (state_r)
      ST_IDLE: begin
        sel_o = sel_i;
      end
      ST_ACCESS: begin
        sel_o = sel_q_r;
      end
      ST_ABORT: begin
        // Downstream is released; the stalled transfer is closed upstream
        // with an error and any late pready from the user IP is dropped.
        sel_o        = sel_q_r;
        user.psel    = 1'b0;
        user.penable = 1'b0;
        apb.pready   = 1'b1;
        apb.prdata   = {DATA_WIDTH{1'b0}};
        apb.pslverr  = 1'b1;
      end
      default: begin
        sel_o = sel_i;
      end
    endcase
  end

endmodule

// File: tb/tb_apb4_user_guard.sv
module tb_apb4_user_guard;

  localparam int T = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sel_i;
  logic [3:0] sel_o;
  logic       timeout_o;
  logic [7:0] abort_cnt_o;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  apb4_if apb_bus ();
  apb4_if user_bus ();

  apb4_user_guard #(
    .TIMEOUT_CYCLES   (T),
    .USER_IPSEL_WIDTH (4),
    .DATA_WIDTH       (32)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sel_i       (sel_i),
    .sel_o       (sel_o),
    .apb         (apb_bus),
    .user        (user_bus),
    .timeout_o   (timeout_o),
    .abort_cnt_o (abort_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One APB transfer. Reference rule: the user answers after `waits` wait
  // cycles; if waits < T the transfer completes normally at access cycle
  // waits, otherwise the guard aborts at access cycle T.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic slv, input int waits,
                      input logic [3:0] sel_a, input logic [3:0] sel_b, input bit idle_after);
    bit done;
    logic [3:0] strb;
    strb = 4'($urandom_range(0, 15));
    @(posedge clk); #1;
    apb_bus.psel    = 1'b1;
    apb_bus.penable = 1'b0;
    apb_bus.paddr   = addr;
    apb_bus.pwrite  = wr;
    apb_bus.pwdata  = wdata;
    apb_bus.pstrb   = strb;
    apb_bus.pprot   = 3'd2;
    user_bus.pready  = 1'b0;
    user_bus.prdata  = 32'd0;
    user_bus.pslverr = 1'b0;
    sel_i = sel_a;
    @(negedge clk);
    chk("setup_psel", user_bus.psel, 1);
    chk("setup_penable", user_bus.penable, 0);
    chk("setup_sel", sel_o, sel_a);
    chk("paddr", user_bus.paddr, addr);
    chk("pwdata", user_bus.pwdata, wdata);
    chk("pstrb", user_bus.pstrb, strb);
    chk("pwrite", user_bus.pwrite, wr);
    done = 0;
    for (int k = 0; k <= T && !done; k++) begin
      @(posedge clk); #1;
      apb_bus.penable  = 1'b1;
      user_bus.pready  = (k == waits);
      user_bus.prdata  = rdata;
      user_bus.pslverr = slv;
      if (k == 1) sel_i = sel_b;
      @(negedge clk);
      if (k < T && k == waits) begin
        chk("done_pready", apb_bus.pready, 1);
        chk("done_prdata", apb_bus.prdata, rdata);
        chk("done_pslverr", apb_bus.pslverr, slv);
        chk("done_timeout", timeout_o, 0);
        chk("done_penable", user_bus.penable, 1);
        chk("done_sel", sel_o, sel_a);
        chk("done_cnt", abort_cnt_o, exp_cnt);
        done = 1;
      end else if (k < T) begin
        chk("wait_pready", apb_bus.pready, 0);
        chk("wait_timeout", timeout_o, 0);
        chk("wait_psel", user_bus.psel, 1);
        chk("wait_sel", sel_o, sel_a);
      end else begin
        exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        chk("abort_pready", apb_bus.pready, 1);
        chk("abort_pslverr", apb_bus.pslverr, 1);
        chk("abort_prdata", apb_bus.prdata, 0);
        chk("abort_timeout", timeout_o, 1);
        chk("abort_psel", user_bus.psel, 0);
        chk("abort_penable", user_bus.penable, 0);
        chk("abort_sel", sel_o, sel_a);
        chk("abort_cnt", abort_cnt_o, exp_cnt);
        done = 1;
      end
    end
    if (idle_after) begin
      @(posedge clk); #1;
      apb_bus.psel    = 1'b0;
      apb_bus.penable = 1'b0;
      user_bus.pready = 1'b0;
      @(negedge clk);
      chk("idle_sel", sel_o, sel_i);
      chk("idle_timeout", timeout_o, 0);
      chk("idle_cnt", abort_cnt_o, exp_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel_i = 4'd5;
    apb_bus.psel    = 1'b0;
    apb_bus.penable = 1'b0;
    apb_bus.paddr   = 32'd0;
    apb_bus.pwrite  = 1'b0;
    apb_bus.pwdata  = 32'd0;
    apb_bus.pstrb   = 4'd0;
    apb_bus.pprot   = 3'd0;
    user_bus.pready  = 1'b0;
    user_bus.prdata  = 32'd0;
    user_bus.pslverr = 1'b0;
    #3;
    chk("rst_timeout", timeout_o, 0);
    chk("rst_cnt", abort_cnt_o, 0);
    chk("rst_sel", sel_o, 5);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait read, sel 2.
    xfer(1'b0, 32'h0000_0010, 32'd0, 32'hA5A5_0001, 1'b0, 0, 4'd2, 4'd2, 1'b1);
    // Write, 3 wait states: completes on the 4th access cycle.
    xfer(1'b1, 32'h0000_0020, 32'h1234_5678, 32'd0, 1'b0, 3, 4'd2, 4'd2, 1'b1);
    // Never ready: abort in the 5th access cycle.
    xfer(1'b0, 32'h0000_0030, 32'd0, 32'hDEAD_BEEF, 1'b0, 100, 4'd7, 4'd7, 1'b1);
    // Late pready arriving exactly in the ABORT cycle is ignored.
    xfer(1'b0, 32'h0000_0034, 32'd0, 32'hCAFE_0000, 1'b0, T, 4'd7, 4'd7, 1'b1);
    // Select change 1 -> 3 during a stalled access.
    xfer(1'b0, 32'h0000_0040, 32'd0, 32'h0BAD_F00D, 1'b1, 3, 4'd1, 4'd3, 1'b1);

    // Randomized transfers, some back-to-back.
    for (int i = 0; i < 80; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, T + 2),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    // Counter saturation.
    for (int i = 0; i < 260; i++) begin
      xfer(1'b1, 32'h100 + i, $urandom, 32'd0, 1'b0, T + 3, 4'd4, 4'd4, 1'b0);
    end
    @(negedge clk);
    chk("sat_cnt", abort_cnt_o, 255);

    // Reset in the middle of an access phase.
    @(posedge clk); #1;
    apb_bus.psel    = 1'b1;
    apb_bus.penable = 1'b0;
    user_bus.pready = 1'b0;
    sel_i = 4'd6;
    @(posedge clk); #1;
    apb_bus.penable = 1'b1;
    @(posedge clk); #1;
    sel_i = 4'd9;
    @(negedge clk);
    chk("pre_rst_sel", sel_o, 6);
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_timeout", timeout_o, 0);
    chk("mid_rst_cnt", abort_cnt_o, 0);
    chk("mid_rst_sel", sel_o, 9);
    chk("mid_rst_psel", user_bus.psel, 1);
    chk("mid_rst_penable", user_bus.penable, 1);
    @(negedge clk);
    rst_n = 1'b1;
    apb_bus.psel    = 1'b0;
    apb_bus.penable = 1'b0;
    xfer(1'b0, 32'h0000_0050, 32'd0, 32'h5555_AAAA, 1'b0, 2, 4'd9, 4'd9, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
